comp_serial_unit: RTL and testbench
===================================

Name: comp_serial_unit

Overview:
- Parametrised, multi-cycle successor to the datapath's combinational two's-complement negator.
- Accepts one WIDTH-bit operand and an op code through a valid/ready handshake.
- Processes the operand in STEP-bit chunks, LSB first, one chunk per cycle.
- Returns the result with overflow and zero flags through a second valid/ready handshake. Sits between register-file read and ALU operand mux; it is the shared sign-manipulation resource for SUB, NEG and ABS instructions.

Parameters:
- WIDTH, 8, operand/result width in bits; must be >= 2.
- STEP, 2, bits processed per cycle; 1 <= STEP <= WIDTH and WIDTH % STEP == 0; elaboration error otherwise.
- N (localparam), WIDTH/STEP, chunk count = busy cycles per operation.

Ports:
- CLK  input  1  rising-edge clock
- RESET_N  input  1  asynchronous, active-low reset
- IN_VALID  input  1  operand and op valid
- IN_READY  output  1  unit can accept an operand
- IN_DATA  input  WIDTH  operand
- IN_OP  input  2  operation: 00 PASS, 01 NEG (two's complement), 10 ABS, 11 INV (ones' complement)
- OUT_VALID  output  1  result valid
- OUT_READY  input  1  consumer accepts result
- OUT_DATA  output  WIDTH  result
- OUT_OVF  output  1  overflow: NEG/ABS applied to 100..0
- OUT_ZERO  output  1  OUT_DATA == 0

Behaviour:
- Clock and reset: single clock CLK. RESET_N is asynchronous and active-low; reset is applied immediately and released synchronously.
- Reset values: state IDLE, IN_READY=1, OUT_VALID=0, OUT_DATA=0, OUT_OVF=0, OUT_ZERO=0. Internal operand/result shift registers, chunk counter and carry are also 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - IN_READY=1.
  - On IN_VALID: latch IN_DATA and IN_OP, and resolve the effective op.
    - ABS with IN_DATA[WIDTH-1]=1 becomes NEG; otherwise ABS becomes PASS.
    - Set carry=1 for NEG, 0 otherwise. Clear the counter. Go to BUSY.
- BUSY:
  - IN_READY=0. Each cycle, process chunk k (bits k*STEP .. k*STEP+STEP-1):
    - PASS: copy bits.
    - INV: invert bits.
    - NEG: invert bits, add carry, propagate carry-out to the next chunk.
  - Exactly N cycles, then DONE. The final carry-out is discarded.
- DONE:
  - OUT_VALID=1. OUT_DATA and flags are registered and stable.
  - On OUT_READY: go to IDLE, OUT_VALID deasserts next cycle.
  - OUT_DATA holds its last value afterwards; it is ignored while OUT_VALID=0.
- Latency: accepted on edge t → OUT_VALID=1 after edge t+N. With STEP=WIDTH, the result is valid one cycle after accept.
- Throughput: one operation per N+2 cycles minimum. IN_READY is high only in IDLE; there is no overlap.
- Flags:
  - OUT_OVF=1 iff the effective op is NEG and the operand is 1 followed by WIDTH-1 zeros. The result is then that same value, unsaturated.
  - OUT_ZERO is computed from the final result. NEG of 0 gives 0 with OUT_ZERO=1 and OUT_OVF=0.
  - PASS and INV never set OUT_OVF.
- Handshake rules:
  - IN_DATA and IN_OP are sampled only on the IN_VALID & IN_READY edge; later changes to them have no effect on the operation in flight.
  - IN_VALID while busy is ignored, not queued.
  - OUT_READY outside DONE is ignored.
  - OUT_READY held high in DONE completes the transfer in exactly one cycle.
- Reset mid-operation (BUSY or DONE): the operation is lost, the reset values apply, and no OUT_VALID pulse occurs.

Decomposition:
- Shared package comp_pkg:
  - op encodings OP_PASS/OP_NEG/OP_ABS/OP_INV
  - state encodings S_IDLE/S_BUSY/S_DONE
- Sub-module comp_chunk: combinational STEP-bit slice with inputs bits, invert, carry_in and outputs bits_out, carry_out. Instantiated once, time-multiplexed by the FSM.
- Top level holds the FSM, counter, shift registers and flag logic.

Test Plan (WIDTH=8, STEP=2, N=4 unless noted):
- NEG 8'b00000111, OUT_READY=1 → OUT_VALID 4 cycles after accept; OUT_DATA=8'b11111001, OVF=0, ZERO=0.
- NEG 8'h80 → OUT_DATA=8'h80, OVF=1. NEG 8'h00 → OUT_DATA=8'h00, ZERO=1, OVF=0.
- ABS 8'hF9 → 8'h07. ABS 8'h05 → 8'h05. INV 8'h0F → 8'hF0. PASS 8'hA5 → 8'hA5. All with OVF=0.
- Backpressure: OUT_READY=0 for 6 cycles in DONE.
  - OUT_DATA and flags hold, IN_READY=0.
  - IN_VALID with 8'h01 during this window is ignored.
  - Releasing OUT_READY returns to IDLE, and the next result belongs only to the next accepted operand.
- Reset: drop RESET_N asynchronously mid-BUSY, between clock edges → outputs reach reset values immediately; after release, NEG 8'h01 → 8'hFF.
- Parameter sweep: STEP=8 with NEG 8'h07 → 8'hF9 one cycle after accept. WIDTH=16, STEP=4 with NEG 16'h8000 → 16'h8000, OVF=1, latency 4.

Source files
------------

// File: rtl/comp_pkg.sv
// Shared definitions for the serial sign-manipulation unit: op codes, FSM states
// and the ABS-to-PASS/NEG resolution helper.
package comp_pkg;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_NEG  = 2'b01;
  localparam logic [1:0] OP_ABS  = 2'b10;
  localparam logic [1:0] OP_INV  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // ABS never reaches the datapath; it collapses to NEG or PASS on the operand sign.
  function automatic logic [1:0] resolve_op(input logic [1:0] op, input logic sign);
    if (op == OP_ABS) begin
      return sign ? OP_NEG : OP_PASS;
    end
    return op;
  endfunction

endpackage

// File: rtl/comp_chunk.sv
// Combinational STEP-bit slice: optional inversion plus carry-in, time-multiplexed
// across the operand by the serial unit.
module comp_chunk #(
  parameter int unsigned STEP = 2
) (
  input  logic [STEP-1:0] bits,
  input  logic            invert,
  input  logic            carry_in,
  output logic [STEP-1:0] bits_out,
  output logic            carry_out
);

  logic [STEP:0] sum;

  assign sum = {1'b0, bits ^ {STEP{invert}}} + {{STEP{1'b0}}, carry_in};
  assign {carry_out, bits_out} = sum;

endmodule

// File: rtl/comp_serial_unit.sv
// Multi-cycle PASS/NEG/ABS/INV unit: processes the operand STEP bits per cycle,
// LSB first, behind valid/ready handshakes on both sides.
module comp_serial_unit
  import comp_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEP  = 2
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic [1:0]       IN_OP,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             OUT_OVF,
  output logic             OUT_ZERO
);

  localparam int unsigned N  = WIDTH / STEP;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2 || STEP < 1 || STEP > WIDTH || (WIDTH % STEP) != 0) begin : g_bad_param
    $error("comp_serial_unit: illegal WIDTH/STEP combination");
  end

  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  opnd_q, opnd_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic              invert_q, invert_d;
  logic              ovf_pend_q, ovf_pend_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  logic [1:0]        eff_op;
  logic [STEP-1:0]   chunk_out;
  logic              chunk_carry;
  logic [WIDTH-1:0]  res_shift;

  comp_chunk #(
    .STEP (STEP)
  ) u_chunk (
    .bits      (opnd_q[STEP-1:0]),
    .invert    (invert_q),
    .carry_in  (carry_q),
    .bits_out  (chunk_out),
    .carry_out (chunk_carry)
  );

  // Result fills from the top so that after N shifts chunk 0 sits at bit 0.
  assign res_shift = (res_q >> STEP) | (WIDTH'(chunk_out) << (WIDTH - STEP));
  assign eff_op    = resolve_op(IN_OP, IN_DATA[WIDTH-1]);

  always_comb begin
    state_d    = state_q;
    opnd_d     = opnd_q;
    res_d      = res_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    invert_d   = invert_q;
    ovf_pend_d = ovf_pend_q;
    out_data_d = out_data_q;
    ovf_d      = ovf_q;
    zero_d     = zero_q;
    unique case (state_q)
      S_IDLE: begin
        if (IN_VALID) begin
          opnd_d     = IN_DATA;
          res_d      = '0;
          cnt_d      = '0;
          carry_d    = (eff_op == OP_NEG);
          invert_d   = (eff_op == OP_NEG) || (eff_op == OP_INV);
          ovf_pend_d = (eff_op == OP_NEG) && (IN_DATA == MinVal);
          state_d    = S_BUSY;
        end
      end
      S_BUSY: begin
        opnd_d  = opnd_q >> STEP;
        res_d   = res_shift;
        carry_d = chunk_carry;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          out_data_d = res_shift;
          zero_d     = (res_shift == '0);
          ovf_d      = ovf_pend_q;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        if (OUT_READY) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      opnd_q     <= '0;
      res_q      <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      invert_q   <= 1'b0;
      ovf_pend_q <= 1'b0;
      out_data_q <= '0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      opnd_q     <= opnd_d;
      res_q      <= res_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      invert_q   <= invert_d;
      ovf_pend_q <= ovf_pend_d;
      out_data_q <= out_data_d;
      ovf_q      <= ovf_d;
      zero_q     <= zero_d;
    end
  end

  assign IN_READY  = (state_q == S_IDLE);
  assign OUT_VALID = (state_q == S_DONE);
  assign OUT_DATA  = out_data_q;
  assign OUT_OVF   = ovf_q;
  assign OUT_ZERO  = zero_q;

endmodule

// File: tb/tb_comp_serial_unit.sv
// Randomised and directed bench for comp_serial_unit at three parameter points,
// checked against an arithmetic reference model.
module tb_comp_serial_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  in_valid;
  logic [15:0] in_data;
  logic [1:0]  in_op;
  logic        out_ready;
  wire  [2:0]  in_ready, out_valid, out_ovf, out_zero;
  wire  [7:0]  od0, od1;
  wire  [15:0] od2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  comp_serial_unit #(.WIDTH(8), .STEP(2)) u_dut (
    .CLK(clk), .RESET_N(rst_n), .IN_VALID(in_valid[0]), .IN_READY(in_ready[0]),
    .IN_DATA(in_data[7:0]), .IN_OP(in_op), .OUT_VALID(out_valid[0]), .OUT_READY(out_ready),
    .OUT_DATA(od0), .OUT_OVF(out_ovf[0]), .OUT_ZERO(out_zero[0])
  );

  comp_serial_unit #(.WIDTH(8), .STEP(8)) u_dut_s8 (
    .CLK(clk), .RESET_N(rst_n), .IN_VALID(in_valid[1]), .IN_READY(in_ready[1]),
    .IN_DATA(in_data[7:0]), .IN_OP(in_op), .OUT_VALID(out_valid[1]), .OUT_READY(out_ready),
    .OUT_DATA(od1), .OUT_OVF(out_ovf[1]), .OUT_ZERO(out_zero[1])
  );

  comp_serial_unit #(.WIDTH(16), .STEP(4)) u_dut_w16 (
    .CLK(clk), .RESET_N(rst_n), .IN_VALID(in_valid[2]), .IN_READY(in_ready[2]),
    .IN_DATA(in_data), .IN_OP(in_op), .OUT_VALID(out_valid[2]), .OUT_READY(out_ready),
    .OUT_DATA(od2), .OUT_OVF(out_ovf[2]), .OUT_ZERO(out_zero[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] rd(input int u);
    case (u)
      0:       return {8'h00, od0};
      1:       return {8'h00, od1};
      default: return od2;
    endcase
  endfunction

  // Returns {ovf, zero, data}: plain arithmetic on the operand value.
  function automatic logic [17:0] model(input int w, input logic [1:0] op, input logic [15:0] x);
    logic [15:0] mask, minv, r;
    logic        neg, ovf;
    mask = 16'((32'd1 << w) - 1);
    minv = 16'(32'd1 << (w - 1));
    neg  = (op == 2'b01) || (op == 2'b10 && (x & minv) != 0);
    if (op == 2'b11)  r = ~x & mask;
    else if (neg)     r = (16'd0 - x) & mask;
    else              r = x;
    ovf = neg && (x == minv);
    return {ovf, (r == 16'd0), r};
  endfunction

  task automatic run_op(input int u, input logic [1:0] op, input logic [15:0] x, input int hold);
    int          w, lat_exp, lat;
    logic [15:0] xm;
    logic [17:0] e;
    w       = (u == 2) ? 16 : 8;
    lat_exp = (u == 1) ? 1 : 4;
    xm      = x & 16'((32'd1 << w) - 1);
    e       = model(w, op, xm);
    lat = 0;
    while (!in_ready[u] && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    check($sformatf("u%0d in_ready idle", u), in_ready[u], 1);
    in_data = xm; in_op = op; in_valid[u] = 1'b1;
    @(posedge clk); #1;
    in_valid[u] = 1'b0;
    in_data = 16'($urandom);
    in_op   = 2'($urandom);
    check($sformatf("u%0d in_ready busy", u), in_ready[u], 0);
    lat = 0;
    while (!out_valid[u] && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    check($sformatf("u%0d latency op%0d x%0h", u, op, xm), lat, lat_exp);
    check($sformatf("u%0d data op%0d x%0h", u, op, xm), rd(u), e[15:0]);
    check($sformatf("u%0d zero op%0d x%0h", u, op, xm), out_zero[u], e[16]);
    check($sformatf("u%0d ovf op%0d x%0h", u, op, xm), out_ovf[u], e[17]);
    for (int i = 0; i < hold; i++) begin
      in_valid[u] = 1'b1; in_data = 16'h0001; in_op = 2'b01;
      @(posedge clk); #1;
      check($sformatf("u%0d hold valid", u), out_valid[u], 1);
      check($sformatf("u%0d hold data", u), {out_ovf[u], out_zero[u], rd(u)}, e);
      check($sformatf("u%0d hold in_ready", u), in_ready[u], 0);
    end
    in_valid[u] = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check($sformatf("u%0d valid drop", u), out_valid[u], 0);
    check($sformatf("u%0d ready back", u), in_ready[u], 1);
  endtask

  initial begin
    logic seen;
    in_valid = '0; in_data = '0; in_op = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", in_ready[0], 1);
    check("reset out_valid", out_valid[0], 0);
    check("reset data", od0, 0);
    check("reset ovf", out_ovf[0], 0);
    check("reset zero", out_zero[0], 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(0, 2'b01, 16'h07, 0);
    run_op(0, 2'b01, 16'h80, 0);
    run_op(0, 2'b01, 16'h00, 0);
    run_op(0, 2'b10, 16'hF9, 0);
    run_op(0, 2'b10, 16'h05, 0);
    run_op(0, 2'b11, 16'h0F, 0);
    run_op(0, 2'b00, 16'hA5, 0);
    run_op(0, 2'b01, 16'h33, 6);
    run_op(0, 2'b00, 16'h22, 0);
    for (int i = 0; i < 30; i++) begin
      run_op(0, 2'($urandom), 16'($urandom), int'($urandom_range(0, 2)));
    end

    // Asynchronous reset mid-BUSY, away from any clock edge.
    run_op(0, 2'b00, 16'h5A, 0);
    in_data = 16'h3C; in_op = 2'b01; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("mid reset in_ready", in_ready[0], 1);
    check("mid reset out_valid", out_valid[0], 0);
    check("mid reset data", od0, 0);
    check("mid reset flags", {out_ovf[0], out_zero[0]}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      seen |= out_valid[0];
    end
    check("no valid after reset", seen, 0);
    run_op(0, 2'b01, 16'h01, 0);

    run_op(1, 2'b01, 16'h07, 0);
    run_op(2, 2'b01, 16'h8000, 0);
    for (int i = 0; i < 6; i++) begin
      run_op(1, 2'($urandom), 16'($urandom), int'($urandom_range(0, 1)));
      run_op(2, 2'($urandom), 16'($urandom), int'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
